mmcm_drp_reconfig: RTL and testbench



---
 rtl/mmcm_drp_reconfig.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_reconfig.sv
// DRP initiator that reprograms an MMCME2_ADV from a host-loaded {addr, mask, data} table.
// Optional readback verify of every write is enabled by defining MMCM_DRP_READBACK_EN.
module mmcm_drp_reconfig #(
   parameter int TBL_AW       = 5,
   parameter int DRDY_TIMEOUT = 63,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tbl_we,
   input  logic [TBL_AW-1:0] tbl_waddr,
   input  logic [38:0]       tbl_wdata,
   input  logic [TBL_AW-1:0] num_regs,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [6:0]        drp_daddr,
   output logic [15:0]       drp_di,
   output logic              drp_den,
   output logic              drp_dwe,
   input  logic [15:0]       drp_do,
   input  logic              drp_drdy,
   output logic              mmcm_rst,
   input  logic              mmcm_locked
);

   localparam int DT_W = $clog2(DRDY_TIMEOUT + 1);
   localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ASSERT, S_RD, S_RD_W, S_WR, S_WR_W, S_VFY, S_VFY_W, S_REL, S_LOCK_W
   } state_t;

   // Mask bit 1 keeps the current register bit, mask bit 0 takes the table data bit.
   function automatic logic [15:0] rmw_merge(input logic [15:0] cur,
                                             input logic [15:0] mask,
                                             input logic [15:0] data);
      return (cur & mask) | (data & ~mask);
   endfunction

   logic [38:0]       tbl_r [2**TBL_AW];
   state_t            state_r, state_s;
   logic [TBL_AW-1:0] idx_r, idx_s;
   logic [TBL_AW-1:0] cnt_r, cnt_s;
   logic [15:0]       rdata_r, rdata_s;
   logic [DT_W-1:0]   dtmr_r, dtmr_s;
   logic [LT_W-1:0]   ltmr_r, ltmr_s;
   logic [3:0]        stale_r, stale_s;
   logic              seen_low_r, seen_low_s;
   logic              busy_s, done_s, error_s, den_s, dwe_s, mmcm_rst_s;
   logic [1:0]        err_code_s;
   logic [6:0]        daddr_s;
   logic [15:0]       di_s;
   logic [38:0]       entry_s;
   logic [TBL_AW:0]   idx_inc_s;
   logic              last_s;
   logic              lock_armed_s;

   // Table RAM: host writes accepted only while no sequence is running; not cleared by rst.
   always_ff @(posedge clk) begin
      if (tbl_we && !busy) begin
         tbl_r[tbl_waddr] <= tbl_wdata;
      end
   end

   assign entry_s      = tbl_r[idx_r];
   assign idx_inc_s    = {1'b0, idx_r} + {{TBL_AW{1'b0}}, 1'b1};
   assign last_s       = (idx_inc_s == {1'b0, cnt_r});
   // LOCKED lags RST, so a high level is trusted only after a low was seen or 8 cycles passed.
   assign lock_armed_s = seen_low_r || (stale_r == 4'd8);

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      cnt_s      = cnt_r;
      rdata_s    = rdata_r;
      dtmr_s     = dtmr_r;
      ltmr_s     = ltmr_r;
      stale_s    = stale_r;
      seen_low_s = seen_low_r;
      busy_s     = busy;
      done_s     = 1'b0;
      error_s    = error;
      err_code_s = err_code;
      daddr_s    = drp_daddr;
      di_s       = drp_di;
      den_s      = 1'b0;
      dwe_s      = 1'b0;
      mmcm_rst_s = mmcm_rst;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               cnt_s      = num_regs;
               idx_s      = {TBL_AW{1'b0}};
               error_s    = 1'b0;
               err_code_s = 2'd0;
               busy_s     = 1'b1;
               mmcm_rst_s = 1'b1;
               state_s    = S_ASSERT;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ASSERT: begin
            if (cnt_r != {TBL_AW{1'b0}}) begin
               state_s = S_RD;
            end else begin
               state_s = S_REL;
            end
         end
         S_RD: begin
            daddr_s = entry_s[38:32];
            den_s   = 1'b1;
            dtmr_s  = {DT_W{1'b0}};
            state_s = S_RD_W;
         end
         S_RD_W: begin
            if (drp_drdy) begin
               rdata_s = drp_do;
               state_s = S_WR;
            end else if (dtmr_r == DT_W'(DRDY_TIMEOUT)) begin
               error_s    = 1'b1;
               err_code_s = 2'd1;
               mmcm_rst_s = 1'b0;
               done_s     = 1'b1;
               busy_s     = 1'b0;
               state_s    = S_IDLE;
            end else begin
               dtmr_s = dtmr_r + {{(DT_W-1){1'b0}}, 1'b1};
            end
         end
         S_WR: begin
            di_s    = rmw_merge(rdata_r, entry_s[31:16], entry_s[15:0]);
            den_s   = 1'b1;
            dwe_s   = 1'b1;
            dtmr_s  = {DT_W{1'b0}};
            state_s = S_WR_W;
         end
         S_WR_W: begin
            if (drp_drdy) begin
`ifdef MMCM_DRP_READBACK_EN
               state_s = S_VFY;
`else
               idx_s   = idx_inc_s[TBL_AW-1:0];
               state_s = last_s ? S_REL : S_RD;
`endif
            end else if (dtmr_r == DT_W'(DRDY_TIMEOUT)) begin
               error_s    = 1'b1;
               err_code_s = 2'd1;
               mmcm_rst_s = 1'b0;
               done_s     = 1'b1;
               busy_s     = 1'b0;
               state_s    = S_IDLE;
            end else begin
               dtmr_s = dtmr_r + {{(DT_W-1){1'b0}}, 1'b1};
            end
         end
`ifdef MMCM_DRP_READBACK_EN
         S_VFY: begin
            den_s   = 1'b1;
            dtmr_s  = {DT_W{1'b0}};
            state_s = S_VFY_W;
         end
         S_VFY_W: begin
            if (drp_drdy) begin
               if (drp_do != drp_di) begin
                  error_s    = 1'b1;
                  err_code_s = 2'd3;
                  mmcm_rst_s = 1'b0;
                  done_s     = 1'b1;
                  busy_s     = 1'b0;
                  state_s    = S_IDLE;
               end else begin
                  idx_s   = idx_inc_s[TBL_AW-1:0];
                  state_s = last_s ? S_REL : S_RD;
               end
            end else if (dtmr_r == DT_W'(DRDY_TIMEOUT)) begin
               error_s    = 1'b1;
               err_code_s = 2'd1;
               mmcm_rst_s = 1'b0;
               done_s     = 1'b1;
               busy_s     = 1'b0;
               state_s    = S_IDLE;
            end else begin
               dtmr_s = dtmr_r + {{(DT_W-1){1'b0}}, 1'b1};
            end
         end
`endif
         S_REL: begin
            mmcm_rst_s = 1'b0;
            ltmr_s     = {LT_W{1'b0}};
            stale_s    = 4'd0;
            seen_low_s = 1'b0;
            state_s    = S_LOCK_W;
         end
         S_LOCK_W: begin
            if (!mmcm_locked) begin
               seen_low_s = 1'b1;
            end else begin
               seen_low_s = seen_low_r;
            end
            if (mmcm_locked && lock_armed_s) begin
               done_s  = 1'b1;
               busy_s  = 1'b0;
               state_s = S_IDLE;
            end else if (ltmr_r == LT_W'(LOCK_TIMEOUT)) begin
               error_s    = 1'b1;
               err_code_s = 2'd2;
               done_s     = 1'b1;
               busy_s     = 1'b0;
               state_s    = S_IDLE;
            end else begin
               ltmr_s = ltmr_r + {{(LT_W-1){1'b0}}, 1'b1};
               if (stale_r != 4'd8) begin
                  stale_s = stale_r + 4'd1;
               end else begin
                  stale_s = stale_r;
               end
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         idx_r      <= {TBL_AW{1'b0}};
         cnt_r      <= {TBL_AW{1'b0}};
         rdata_r    <= 16'h0000;
         dtmr_r     <= {DT_W{1'b0}};
         ltmr_r     <= {LT_W{1'b0}};
         stale_r    <= 4'd0;
         seen_low_r <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         err_code   <= 2'd0;
         drp_daddr  <= 7'd0;
         drp_di     <= 16'h0000;
         drp_den    <= 1'b0;
         drp_dwe    <= 1'b0;
         mmcm_rst   <= 1'b0;
      end else begin
         state_r    <= state_s;
         idx_r      <= idx_s;
         cnt_r      <= cnt_s;
         rdata_r    <= rdata_s;
         dtmr_r     <= dtmr_s;
         ltmr_r     <= ltmr_s;
         stale_r    <= stale_s;
         seen_low_r <= seen_low_s;
         busy       <= busy_s;
         done       <= done_s;
         error      <= error_s;
         err_code   <= err_code_s;
         drp_daddr  <= daddr_s;
         drp_di     <= di_s;
         drp_den    <= den_s;
         drp_dwe    <= dwe_s;
         mmcm_rst   <= mmcm_rst_s;
      end
   end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Self-checking bench for mmcm_drp_reconfig: table-driven RMW vectors plus directed corner sequences,
// with a behavioural DRP responder and MMCM lock model.
module tb_mmcm_drp_reconfig;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tbl_we = 1'b0;
   logic [4:0]  tbl_waddr = 5'd0;
   logic [38:0] tbl_wdata = 39'd0;
   logic [4:0]  num_regs = 5'd0;
   logic        start = 1'b0;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_di;
   logic        drp_den, drp_dwe;
   logic [15:0] drp_do = 16'h0000;
   logic        drp_drdy = 1'b0;
   logic        mmcm_rst;
   logic        mmcm_locked = 1'b0;

   mmcm_drp_reconfig dut (
      .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
      .num_regs(num_regs), .start(start), .busy(busy), .done(done), .error(error),
      .err_code(err_code), .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den),
      .drp_dwe(drp_dwe), .drp_do(drp_do), .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst),
      .mmcm_locked(mmcm_locked)
   );

   always #5 clk = ~clk;

   // Responder configuration, set by the stimulus process.
   int          lat = 3;
   bit          no_drdy = 1'b0;
   bit          corrupt = 1'b0;
   logic [15:0] rd_val = 16'hFFFF;
   int          lock_mode = 0;
   int          lock_delay = 20;

   // Responder bookkeeping.
   int          n_rd = 0, n_wr = 0, n_vfy = 0, n_overlap = 0, n_rst_viol = 0, n_dwe_alone = 0;
   logic [6:0]  rd_addr_log [64];
   logic [6:0]  wr_addr_log [64];
   logic [15:0] wr_data_log [64];
   bit          pend = 1'b0, pend_vfy = 1'b0, last_wr = 1'b0;
   int          cnt = 0;
   logic [6:0]  last_waddr = 7'd0;
   logic [15:0] last_wdata = 16'h0000;
   int          rel_cnt = 0;

   // DRP responder: a read following a write to the same address is a verify read.
   always @(posedge clk) begin
      drp_drdy <= 1'b0;
      if (!mmcm_rst) last_wr <= 1'b0;
      if (drp_dwe && !drp_den) n_dwe_alone <= n_dwe_alone + 1;
      if (drp_den) begin
         if (pend) n_overlap <= n_overlap + 1;
         if (!mmcm_rst) n_rst_viol <= n_rst_viol + 1;
         if (drp_dwe) begin
            wr_addr_log[n_wr % 64] <= drp_daddr;
            wr_data_log[n_wr % 64] <= drp_di;
            n_wr       <= n_wr + 1;
            last_wr    <= 1'b1;
            last_waddr <= drp_daddr;
            last_wdata <= drp_di;
            pend_vfy   <= 1'b0;
         end else if (last_wr && drp_daddr == last_waddr) begin
            n_vfy    <= n_vfy + 1;
            pend_vfy <= 1'b1;
            last_wr  <= 1'b0;
         end else begin
            rd_addr_log[n_rd % 64] <= drp_daddr;
            n_rd     <= n_rd + 1;
            pend_vfy <= 1'b0;
         end
         pend <= !no_drdy;
         cnt  <= lat;
      end else if (pend) begin
         if (cnt <= 1) begin
            drp_drdy <= 1'b1;
            drp_do   <= pend_vfy ? (last_wdata ^ {15'd0, corrupt}) : rd_val;
            pend     <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   // MMCM lock model: 0 = lock lock_delay cycles after release, 1 = always high, 2 = never.
   always @(posedge clk) begin
      if (lock_mode == 0) begin
         if (mmcm_rst) begin
            mmcm_locked <= 1'b0;
            rel_cnt     <= 0;
         end else if (rel_cnt < lock_delay) begin
            rel_cnt <= rel_cnt + 1;
         end else begin
            mmcm_locked <= 1'b1;
         end
      end else if (lock_mode == 1) begin
         mmcm_locked <= 1'b1;
      end else begin
         mmcm_locked <= 1'b0;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic load(input logic [4:0] idx, input logic [6:0] a, input logic [15:0] m,
                       input logic [15:0] d);
      tbl_we    = 1'b1;
      tbl_waddr = idx;
      tbl_wdata = {a, m, d};
      @(negedge clk);
      tbl_we = 1'b0;
   endtask

   task automatic pulse_start(input logic [4:0] n);
      start    = 1'b1;
      num_regs = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc, output bit got);
      got = 1'b0;
      cyc = 0;
      while (cyc < budget && !got) begin
         if (done) got = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   typedef struct {
      logic [6:0]  addr;
      logic [15:0] mask;
      logic [15:0] data;
      logic [15:0] rdv;
      logic [15:0] exp_di;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int  cyc;
      bit  got;
      int  rd0, wr0, vf0, ov0;

      vecs[0] = '{7'h08, 16'h1000, 16'h0145, 16'hFFFF, 16'h1145};
      vecs[1] = '{7'h09, 16'hFF00, 16'h00AA, 16'h1234, 16'h12AA};
      vecs[2] = '{7'h14, 16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF};
      vecs[3] = '{7'h7F, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h5A5A};
      vecs[4] = '{7'h00, 16'h0F0F, 16'h1234, 16'hABCD, 16'h1B3D};
      vecs[5] = '{7'h15, 16'h00FF, 16'hFFFF, 16'h0000, 16'hFF00};

      // Reset values.
      @(negedge clk);
      idle(3);
      chk("reset_outputs", {busy, done, error, err_code, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // First run: busy on the cycle after start, 0xFFFF readback, lock 20 cycles after release.
      load(5'd0, 7'h08, 16'h1000, 16'h0145);
      rd0 = n_rd; wr0 = n_wr; ov0 = n_overlap;
      pulse_start(5'd1);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("mmcm_rst_held", {31'd0, mmcm_rst}, 32'd1);
      wait_done(500, cyc, got);
      chk("first_done", {31'd0, got}, 32'd1);
      chk("first_error", {31'd0, error}, 32'd0);
      chk("first_rd_cnt", n_rd - rd0, 32'd1);
      chk("first_wr_cnt", n_wr - wr0, 32'd1);
      chk("first_rd_addr", {25'd0, rd_addr_log[rd0 % 64]}, 32'h08);
      chk("first_wr_di", {16'd0, wr_data_log[wr0 % 64]}, 32'h1145);
      chk("first_rst_low_at_end", {31'd0, mmcm_rst}, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);

      // Table-driven read-modify-write vectors.
      for (int i = 0; i < 6; i++) begin
         load(5'd0, vecs[i].addr, vecs[i].mask, vecs[i].data);
         rd_val = vecs[i].rdv;
         rd0 = n_rd; wr0 = n_wr;
         pulse_start(5'd1);
         wait_done(500, cyc, got);
         chk($sformatf("vec%0d_done", i), {31'd0, got}, 32'd1);
         chk($sformatf("vec%0d_rd_addr", i), {25'd0, rd_addr_log[rd0 % 64]}, {25'd0, vecs[i].addr});
         chk($sformatf("vec%0d_wr_addr", i), {25'd0, wr_addr_log[wr0 % 64]}, {25'd0, vecs[i].addr});
         chk($sformatf("vec%0d_wr_di", i), {16'd0, wr_data_log[wr0 % 64]}, {16'd0, vecs[i].exp_di});
         chk($sformatf("vec%0d_error", i), {31'd0, error}, 32'd0);
         idle(2);
      end

      // Reset mid-sequence, then confirm the table survived.
      lat = 20;
      pulse_start(5'd1);
      idle(5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_outputs", {busy, done, error, err_code, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst}, 32'd0);
      idle(30);
      lat = 3;
      wr0 = n_wr;
      pulse_start(5'd1);
      wait_done(500, cyc, got);
      chk("midrst_rerun_done", {31'd0, got}, 32'd1);
      chk("midrst_table_kept", {16'd0, wr_data_log[wr0 % 64]}, 32'hFF00);

      // Three entries in address order; a start pulse while busy is ignored.
      rd_val = 16'hFFFF;
      load(5'd0, 7'h08, 16'h1000, 16'h0145);
      load(5'd1, 7'h09, 16'h0000, 16'h0001);
      load(5'd2, 7'h14, 16'hFFFF, 16'h0000);
      rd0 = n_rd; wr0 = n_wr; ov0 = n_overlap;
      pulse_start(5'd3);
      idle(10);
      pulse_start(5'd3);
      wait_done(1000, cyc, got);
      chk("multi_done", {31'd0, got}, 32'd1);
      idle(10);
      chk("multi_busy_after", {31'd0, busy}, 32'd0);
      chk("multi_rd_cnt", n_rd - rd0, 32'd3);
      chk("multi_wr_cnt", n_wr - wr0, 32'd3);
      chk("multi_rd_order", {rd_addr_log[rd0 % 64], rd_addr_log[(rd0 + 1) % 64], rd_addr_log[(rd0 + 2) % 64]},
          {7'h08, 7'h09, 7'h14});
      chk("multi_wr_order", {wr_addr_log[wr0 % 64], wr_addr_log[(wr0 + 1) % 64], wr_addr_log[(wr0 + 2) % 64]},
          {7'h08, 7'h09, 7'h14});
      chk("multi_overlap", n_overlap - ov0, 32'd0);
      chk("rst_held_all_dens", n_rst_viol, 32'd0);
      chk("dwe_without_den", n_dwe_alone, 32'd0);

      // DRDY never arrives: timeout, rst released; next start clears the error.
      no_drdy = 1'b1;
      pulse_start(5'd1);
      wait_done(300, cyc, got);
      chk("drdy_to_done", {31'd0, got}, 32'd1);
      chk("drdy_to_not_early", {31'd0, (cyc >= 60)}, 32'd1);
      chk("drdy_to_not_late", {31'd0, (cyc <= 75)}, 32'd1);
      chk("drdy_to_error", {29'd0, error, err_code}, 32'd5);
      chk("drdy_to_rst_low", {31'd0, mmcm_rst}, 32'd0);
      no_drdy = 1'b0;
      idle(2);
      pulse_start(5'd0);
      chk("start_clears_error", {29'd0, error, err_code}, 32'd0);
      wait_done(500, cyc, got);
      chk("clear_run_done", {31'd0, got && !error}, 32'd1);

      // Stale LOCKED: held high throughout, done must wait out the stale window.
      lock_mode = 1;
      idle(2);
      pulse_start(5'd1);
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         if (!mmcm_rst) got = 1'b1;
         else @(negedge clk);
      end
      chk("stale_rst_release", {31'd0, got}, 32'd1);
      wait_done(100, cyc, got);
      chk("stale_done", {31'd0, got}, 32'd1);
      chk("stale_no_early_done", {31'd0, (cyc >= 8)}, 32'd1);
      chk("stale_error", {31'd0, error}, 32'd0);
      lock_mode = 0;
      idle(3);

      // Corrupted verify readback.
      load(5'd0, 7'h08, 16'h1000, 16'h0145);
      corrupt = 1'b1;
      vf0 = n_vfy;
      pulse_start(5'd1);
      wait_done(500, cyc, got);
      chk("rb_done", {31'd0, got}, 32'd1);
`ifdef MMCM_DRP_READBACK_EN
      chk("rb_error", {29'd0, error, err_code}, 32'd7);
      chk("rb_vfy_reads", n_vfy - vf0, 32'd1);
`else
      chk("rb_error", {29'd0, error, err_code}, 32'd0);
      chk("rb_vfy_reads", n_vfy - vf0, 32'd0);
`endif
      chk("rb_rst_low", {31'd0, mmcm_rst}, 32'd0);
      corrupt = 1'b0;
      idle(3);

      // LOCKED never rises after release.
      lock_mode = 2;
      pulse_start(5'd0);
      wait_done(70000, cyc, got);
      chk("lock_to_done", {31'd0, got}, 32'd1);
      chk("lock_to_not_early", {31'd0, (cyc >= 65530)}, 32'd1);
      chk("lock_to_error", {29'd0, error, err_code}, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
